// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC register reader: register map, FSM states,
// register index type and the decoded display snapshot.
package rtc_pkg;

  localparam int NUM_REGS = 10;

  typedef logic [3:0] reg_idx_t;

  localparam reg_idx_t IDX_FIRST = 4'd0;
  localparam reg_idx_t IDX_LAST  = 4'd9;

  localparam logic [7:0] ADDR_SS   = 8'h21;
  localparam logic [7:0] ADDR_MM   = 8'h22;
  localparam logic [7:0] ADDR_HH   = 8'h23;
  localparam logic [7:0] ADDR_DAY  = 8'h24;
  localparam logic [7:0] ADDR_MES  = 8'h25;
  localparam logic [7:0] ADDR_YEAR = 8'h26;
  localparam logic [7:0] ADDR_WDAY = 8'h27;
  localparam logic [7:0] ADDR_SS_T = 8'h41;
  localparam logic [7:0] ADDR_MM_T = 8'h42;
  localparam logic [7:0] ADDR_HH_T = 8'h43;

  // Phases of one address-write plus data-read transaction.
  typedef enum logic [2:0] {
    BUS_IDLE,
    BUS_ADDR_SET,
    BUS_ADDR_WR,
    BUS_ADDR_HOLD,
    BUS_DATA_SET,
    BUS_DATA_RD,
    BUS_DATA_HOLD
  } bus_state_t;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_SWEEP,
    SEQ_COMMIT
  } seq_state_t;

  // Decoded display fields; one copy is filled during a sweep, one is shown.
  typedef struct packed {
    logic [3:0] ss0,   ss1;
    logic [3:0] mm0,   mm1;
    logic [3:0] hh0,   hh1;
    logic       am_pm;
    logic [3:0] day0,  day1;
    logic [3:0] mes0,  mes1;
    logic [3:0] year0, year1;
    logic [2:0] wday;
    logic [3:0] sst0,  sst1;
    logic [3:0] mmt0,  mmt1;
    logic [3:0] hht0,  hht1;
  } snapshot_t;

  // Sweep order to RTC register address.
  function automatic logic [7:0] reg_addr(input reg_idx_t idx);
    case (idx)
      4'd0:    return ADDR_SS;
      4'd1:    return ADDR_MM;
      4'd2:    return ADDR_HH;
      4'd3:    return ADDR_DAY;
      4'd4:    return ADDR_MES;
      4'd5:    return ADDR_YEAR;
      4'd6:    return ADDR_WDAY;
      4'd7:    return ADDR_SS_T;
      4'd8:    return ADDR_MM_T;
      4'd9:    return ADDR_HH_T;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_cycle.sv
// One RTC bus transaction: drive the register address with a wr_n strobe,
// then release the bus and sample the data byte under a rd_n strobe.
// A new start accepted in DATA_HOLD chains straight into the next ADDR_SET.
module rtc_bus_cycle
  import rtc_pkg::*;
#(
  parameter int PULSE_CYC = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic       done,
  output logic [7:0] data
);

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);

  bus_state_t state, state_next;
  logic [7:0] pulse_cnt;
  logic [7:0] addr_q;
  logic       launch;
  logic       pulse_end;

  assign pulse_end = (pulse_cnt == PULSE_LAST);

  // State register; reset returns the pads to the idle bus immediately.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BUS_IDLE;
    else        state <= state_next;
  end

  // Strobe width counter, latched address and captured data byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt <= '0;
      addr_q    <= '0;
      data      <= '0;
    end else begin
      if (launch) addr_q <= addr;
      if ((state == BUS_ADDR_WR) || (state == BUS_DATA_RD))
        pulse_cnt <= pulse_end ? 8'd0 : pulse_cnt + 8'd1;
      else
        pulse_cnt <= '0;
      if ((state == BUS_DATA_RD) && pulse_end) data <= ad_in;
    end
  end

  // Next-state and pad decode; pads are pure functions of the state.
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    done       = 1'b0;
    cs_n       = 1'b1;
    rd_n       = 1'b1;
    wr_n       = 1'b1;
    a_d        = 1'b0;
    ad_oe      = 1'b0;
    ad_out     = 8'h00;
    case (state)
      BUS_IDLE: begin
        if (start) begin
          launch     = 1'b1;
          state_next = BUS_ADDR_SET;
        end
      end
      BUS_ADDR_SET: begin
        cs_n       = 1'b0;
        ad_oe      = 1'b1;
        ad_out     = addr_q;
        state_next = BUS_ADDR_WR;
      end
      BUS_ADDR_WR: begin
        cs_n   = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_q;
        wr_n   = 1'b0;
        if (pulse_end) state_next = BUS_ADDR_HOLD;
      end
      BUS_ADDR_HOLD: begin
        cs_n       = 1'b0;
        ad_oe      = 1'b1;
        ad_out     = addr_q;
        state_next = BUS_DATA_SET;
      end
      BUS_DATA_SET: begin
        cs_n       = 1'b0;
        a_d        = 1'b1;
        state_next = BUS_DATA_RD;
      end
      BUS_DATA_RD: begin
        cs_n = 1'b0;
        a_d  = 1'b1;
        rd_n = 1'b0;
        if (pulse_end) state_next = BUS_DATA_HOLD;
      end
      BUS_DATA_HOLD: begin
        done = 1'b1;
        if (start) begin
          launch     = 1'b1;
          state_next = BUS_ADDR_SET;
        end else begin
          state_next = BUS_IDLE;
        end
      end
      default: state_next = BUS_IDLE;
    endcase
  end

endmodule

// File: rtl/rtc_register_reader.sv
// Periodically sweeps the ten RTC time/date/timer registers, decodes each BCD
// byte into display fields and commits the whole set at once per sweep.
module rtc_register_reader
  import rtc_pkg::*;
#(
  parameter int PULSE_CYC   = 10,
  parameter int REFRESH_CYC = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [3:0] digit0_SS,
  output logic [3:0] digit1_SS,
  output logic [3:0] digit0_MM,
  output logic [3:0] digit1_MM,
  output logic [3:0] digit0_HH,
  output logic [3:0] digit1_HH,
  output logic [3:0] digit0_DAY,
  output logic [3:0] digit1_DAY,
  output logic [3:0] digit0_MES,
  output logic [3:0] digit1_MES,
  output logic [3:0] digit0_YEAR,
  output logic [3:0] digit1_YEAR,
  output logic [3:0] digit0_SS_T,
  output logic [3:0] digit1_SS_T,
  output logic [3:0] digit0_MM_T,
  output logic [3:0] digit1_MM_T,
  output logic [3:0] digit0_HH_T,
  output logic [3:0] digit1_HH_T,
  output logic       AM_PM,
  output logic [2:0] dia_semana,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [24:0] REFRESH_LAST = 25'(REFRESH_CYC - 1);

  seq_state_t  seq_state, seq_next;
  reg_idx_t    idx;
  logic        kick;
  logic [24:0] refresh_cnt;
  logic        refresh_tc;
  logic        sweep_start;
  logic        bus_start;
  logic [7:0]  bus_addr;
  logic        bus_done;
  logic [7:0]  bus_data;
  snapshot_t   shadow;
  snapshot_t   snap;

  rtc_bus_cycle #(
    .PULSE_CYC(PULSE_CYC)
  ) u_bus (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bus_start),
    .addr  (bus_addr),
    .ad_in (ad_in),
    .ad_out(ad_out),
    .ad_oe (ad_oe),
    .cs_n  (cs_n),
    .rd_n  (rd_n),
    .wr_n  (wr_n),
    .a_d   (a_d),
    .done  (bus_done),
    .data  (bus_data)
  );

  assign refresh_tc = (refresh_cnt == REFRESH_LAST);

  // Sequencer decode: start a sweep on the post-reset kick or an idle terminal
  // count, chain register slots back to back, then one commit cycle.
  always_comb begin
    seq_next    = seq_state;
    sweep_start = 1'b0;
    bus_start   = 1'b0;
    bus_addr    = reg_addr(idx);
    case (seq_state)
      SEQ_IDLE: begin
        if (kick || refresh_tc) begin
          sweep_start = 1'b1;
          bus_start   = 1'b1;
          bus_addr    = reg_addr(IDX_FIRST);
          seq_next    = SEQ_SWEEP;
        end
      end
      SEQ_SWEEP: begin
        if (bus_done) begin
          if (idx == IDX_LAST) begin
            seq_next = SEQ_COMMIT;
          end else begin
            bus_start = 1'b1;
            bus_addr  = reg_addr(reg_idx_t'(idx + 4'd1));
          end
        end
      end
      SEQ_COMMIT: seq_next = SEQ_IDLE;
      default:    seq_next = SEQ_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq_state <= SEQ_IDLE;
    else        seq_state <= seq_next;
  end

  // Post-reset kick, register index and free-running refresh counter.
  // A terminal count seen while busy simply wraps without starting anything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kick        <= 1'b1;
      idx         <= IDX_FIRST;
      refresh_cnt <= '0;
    end else begin
      kick <= 1'b0;
      if (sweep_start)
        idx <= IDX_FIRST;
      else if ((seq_state == SEQ_SWEEP) && bus_done && (idx != IDX_LAST))
        idx <= reg_idx_t'(idx + 4'd1);
      if (sweep_start || refresh_tc) refresh_cnt <= '0;
      else                           refresh_cnt <= refresh_cnt + 25'd1;
    end
  end

  // Decode each captured byte into its shadow fields as its slot completes.
  // NOTE: shadow has no reset; every field is rewritten each sweep before it is committed.
  always_ff @(posedge clk) begin
    if ((seq_state == SEQ_SWEEP) && bus_done) begin
      case (idx)
        4'd0: {shadow.ss1, shadow.ss0}     <= bus_data;
        4'd1: {shadow.mm1, shadow.mm0}     <= bus_data;
        4'd2: begin
          shadow.am_pm <= bus_data[7];
          shadow.hh1   <= {2'b00, bus_data[5:4]};
          shadow.hh0   <= bus_data[3:0];
        end
        4'd3: {shadow.day1, shadow.day0}   <= bus_data;
        4'd4: {shadow.mes1, shadow.mes0}   <= bus_data;
        4'd5: {shadow.year1, shadow.year0} <= bus_data;
        4'd6: shadow.wday                  <= bus_data[2:0];
        4'd7: {shadow.sst1, shadow.sst0}   <= bus_data;
        4'd8: {shadow.mmt1, shadow.mmt0}   <= bus_data;
        4'd9: begin
          shadow.hht1 <= {2'b00, bus_data[5:4]};
          shadow.hht0 <= bus_data[3:0];
        end
        default: ;
      endcase
    end
  end

  // Displayed snapshot: replaced only in the commit cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       snap <= '0;
    else if (seq_state == SEQ_COMMIT) snap <= shadow;
  end

  assign busy        = (seq_state != SEQ_IDLE);
  assign frame_done  = (seq_state == SEQ_COMMIT);

  assign digit0_SS   = snap.ss0;
  assign digit1_SS   = snap.ss1;
  assign digit0_MM   = snap.mm0;
  assign digit1_MM   = snap.mm1;
  assign digit0_HH   = snap.hh0;
  assign digit1_HH   = snap.hh1;
  assign AM_PM       = snap.am_pm;
  assign digit0_DAY  = snap.day0;
  assign digit1_DAY  = snap.day1;
  assign digit0_MES  = snap.mes0;
  assign digit1_MES  = snap.mes1;
  assign digit0_YEAR = snap.year0;
  assign digit1_YEAR = snap.year1;
  assign dia_semana  = snap.wday;
  assign digit0_SS_T = snap.sst0;
  assign digit1_SS_T = snap.sst1;
  assign digit0_MM_T = snap.mmt0;
  assign digit1_MM_T = snap.mmt1;
  assign digit0_HH_T = snap.hht0;
  assign digit1_HH_T = snap.hht1;

endmodule

// File: tb/tb_rtc_register_reader.sv
// Bench for rtc_register_reader: two instances (short strobes / tight refresh)
// share one behavioural RTC register file; outputs are compared to a model.
`timescale 1ns/1ps
module tb_rtc_register_reader;

  localparam int P_A = 3;
  localparam int R_A = 120;
  localparam int P_B = 10;
  localparam int R_B = 150;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n;
  wire  [1:0][7:0]  ad_in;
  wire  [1:0][7:0]  ad_out;
  wire  [1:0]       ad_oe, cs_n, rd_n, wr_n, a_d, busy, frame_done;
  wire  [1:0][75:0] obs;
  logic [7:0]       lat [2];
  logic [7:0]       mem [256];

  int passed = 0;
  int total  = 0;
  int cycle  = 0;
  int sweeps [2];
  int viol   [2];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Expected display vector straight from the RTC byte contents.
  function automatic logic [75:0] model();
    logic [75:0] m;
    m[7:0]   = mem[8'h21];
    m[15:8]  = mem[8'h22];
    m[23:16] = mem[8'h23] & 8'h3F;
    m[31:24] = mem[8'h24];
    m[39:32] = mem[8'h25];
    m[47:40] = mem[8'h26];
    m[55:48] = mem[8'h41];
    m[63:56] = mem[8'h42];
    m[71:64] = mem[8'h43] & 8'h3F;
    m[72]    = mem[8'h23][7];
    m[75:73] = mem[8'h27][2:0];
    return m;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int P   = (g == 0) ? P_A : P_B;
    localparam int R   = (g == 0) ? R_A : R_B;
    localparam int L   = 10 * (4 + 2 * P) + 1;
    localparam int PER = ((L + R - 1) / R) * R;

    rtc_register_reader #(.PULSE_CYC(P), .REFRESH_CYC(R)) dut (
      .clk(clk), .rst_n(rst_n[g]), .ad_in(ad_in[g]), .ad_out(ad_out[g]),
      .ad_oe(ad_oe[g]), .cs_n(cs_n[g]), .rd_n(rd_n[g]), .wr_n(wr_n[g]), .a_d(a_d[g]),
      .digit0_SS(obs[g][3:0]),     .digit1_SS(obs[g][7:4]),
      .digit0_MM(obs[g][11:8]),    .digit1_MM(obs[g][15:12]),
      .digit0_HH(obs[g][19:16]),   .digit1_HH(obs[g][23:20]),
      .digit0_DAY(obs[g][27:24]),  .digit1_DAY(obs[g][31:28]),
      .digit0_MES(obs[g][35:32]),  .digit1_MES(obs[g][39:36]),
      .digit0_YEAR(obs[g][43:40]), .digit1_YEAR(obs[g][47:44]),
      .digit0_SS_T(obs[g][51:48]), .digit1_SS_T(obs[g][55:52]),
      .digit0_MM_T(obs[g][59:56]), .digit1_MM_T(obs[g][63:60]),
      .digit0_HH_T(obs[g][67:64]), .digit1_HH_T(obs[g][71:68]),
      .AM_PM(obs[g][72]), .dia_semana(obs[g][75:73]),
      .busy(busy[g]), .frame_done(frame_done[g])
    );

    // Behavioural RTC: address latched under wr_n, data returned under rd_n.
    always @(posedge clk) if (!wr_n[g]) lat[g] <= ad_out[g];
    assign ad_in[g] = rd_n[g] ? 8'hEE : mem[lat[g]];

    int wr_run, rd_run, slen, last_start;
    bit start_ok, in_sweep, prev_busy, prev_cs, prev_fd;
    logic [79:0] aseq;
    logic [75:0] prev_obs;

    // Bus protocol, sweep shape, refresh period and output stability monitor.
    always @(negedge clk) begin
      if (!rst_n[g]) begin
        wr_run = 0; rd_run = 0; start_ok = 0; in_sweep = 0;
        prev_busy = 0; prev_cs = 1; prev_fd = 0; prev_obs = obs[g];
      end else begin
        if (busy[g] && !prev_busy) begin
          if (start_ok) check($sformatf("refresh_period_%0d", g), cycle - last_start, PER);
          last_start = cycle; start_ok = 1; in_sweep = 1; slen = 0; aseq = '0;
        end
        if (busy[g]) slen++;
        if (!cs_n[g] && prev_cs) aseq = {aseq[71:0], ad_out[g]};
        if (!busy[g] && prev_busy && in_sweep) begin
          check($sformatf("sweep_len_%0d", g), slen, L);
          check($sformatf("addr_seq_%0d", g), aseq, 80'h21222324252627414243);
          sweeps[g]++;
          in_sweep = 0;
        end
        if (!wr_n[g]) wr_run++;
        else if (wr_run != 0) begin
          if (wr_run != P) viol[g]++;
          wr_run = 0;
        end
        if (!rd_n[g]) rd_run++;
        else if (rd_run != 0) begin
          if (rd_run != P) viol[g]++;
          rd_run = 0;
        end
        if ((ad_oe[g] && !rd_n[g]) || (!rd_n[g] && !wr_n[g])) viol[g]++;
        if (!busy[g] && (!cs_n[g] || !rd_n[g] || !wr_n[g] || a_d[g] || ad_oe[g] || ad_out[g] != 8'h00))
          viol[g]++;
        if (obs[g] != prev_obs && !prev_fd) viol[g]++;
        prev_busy = busy[g]; prev_cs = cs_n[g]; prev_fd = frame_done[g]; prev_obs = obs[g];
      end
    end
  end

  task automatic wait_busy(input int g, input logic val, input string name);
    int n = 0;
    while (busy[g] !== val && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, busy[g], val);
  endtask

  task automatic wait_fd(input int g, input string name);
    int n = 0;
    while (frame_done[g] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, frame_done[g], 1'b1);
  endtask

  task automatic wait_sweep_start(input int g);
    wait_busy(g, 1'b0, "wait_idle");
    wait_busy(g, 1'b1, "wait_sweep");
  endtask

  // Sweep with fresh RTC contents and land one cycle after the commit.
  task automatic run_frame();
    wait_sweep_start(0);
    wait_fd(0, "wait_frame_done");
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] ss, mm, hh, day, mes, year, wd, sst, mmt, hht;
    logic       exp_ampm;
    logic [3:0] exp_hh1;
    logic [2:0] exp_dia;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{8'h30, 8'h45, 8'h91, 8'h15, 8'h07, 8'h24, 8'h03, 8'h12, 8'h34, 8'h56, 1'b1, 4'd1, 3'd3};
    vecs[1] = '{8'h00, 8'h01, 8'h12, 8'h31, 8'h12, 8'h9A, 8'hFE, 8'h00, 8'h00, 8'h00, 1'b0, 4'd1, 3'd6};
    vecs[2] = '{8'h59, 8'h59, 8'h7F, 8'h28, 8'h02, 8'h00, 8'h07, 8'h59, 8'h59, 8'h23, 1'b0, 4'd3, 3'd7};
    vecs[3] = '{8'h11, 8'h22, 8'hC2, 8'h01, 8'h10, 8'h99, 8'h01, 8'h33, 8'h44, 8'hE5, 1'b1, 4'd0, 3'd1};
    vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 4'd3, 3'd7};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0, 3'd0};

    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    rst_n = 2'b00;
    repeat (3) @(negedge clk);

    // Reset state of the bus and display.
    check("rst_cs_n", cs_n[0], 1'b1);
    check("rst_strobes", {rd_n[0], wr_n[0]}, 2'b11);
    check("rst_a_d_oe", {a_d[0], ad_oe[0]}, 2'b00);
    check("rst_ad_out", ad_out[0], 8'h00);
    check("rst_busy_fd", {busy[0], frame_done[0]}, 2'b00);
    check("rst_outputs", obs[0], 76'h0);

    mem[8'h21] = 8'h30; mem[8'h22] = 8'h45; mem[8'h23] = 8'h91;
    rst_n = 2'b11;
    check("busy_before_edge", busy[0], 1'b0);
    @(posedge clk); #1;
    check("first_addr_set_cs", {cs_n[0], a_d[0], ad_oe[0], wr_n[0]}, 4'b0011);
    check("first_addr_set_addr", ad_out[0], 8'h21);
    check("first_busy", busy, 2'b11);
    @(negedge clk);
    wait_fd(0, "first_frame_done");
    @(negedge clk);
    check("first_ampm", obs[0][72], 1'b1);
    check("first_hh", obs[0][23:16], 8'h11);
    check("first_mm", obs[0][15:8], 8'h45);
    check("first_ss", obs[0][7:0], 8'h30);

    // SS changes after its slot: display holds the earlier snapshot until commit.
    mem[8'h21] = 8'h59;
    wait_sweep_start(0);
    begin
      int n = 0;
      while (!(ad_oe[0] && ad_out[0] == 8'h22) && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("reach_mm_slot", ad_out[0], 8'h22);
    end
    mem[8'h21] = 8'h00;
    wait_fd(0, "mid_frame_done");
    check("ss_held_in_commit", obs[0][7:0], 8'h30);
    @(negedge clk);
    check("ss_after_commit", obs[0][7:0], 8'h59);
    run_frame();
    check("ss_next_sweep", obs[0][7:0], 8'h00);

    // Reset during the data strobe of the fifth register.
    wait_sweep_start(0);
    begin
      int n = 0;
      while (!(!rd_n[0] && lat[0] == 8'h25) && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("reach_mes_read", {rd_n[0], a_d[0], lat[0]}, {1'b0, 1'b1, 8'h25});
    end
    rst_n[0] = 1'b0;
    #1;
    check("midrst_strobes", {rd_n[0], wr_n[0], cs_n[0]}, 3'b111);
    check("midrst_bus", {ad_oe[0], a_d[0], ad_out[0]}, 10'h0);
    check("midrst_flags", {busy[0], frame_done[0]}, 2'b00);
    check("midrst_outputs", obs[0], 76'h0);
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    @(posedge clk); #1;
    check("restart_addr_set", {cs_n[0], busy[0], ad_out[0]}, {1'b0, 1'b1, 8'h21});
    @(negedge clk);

    // Table-driven decode vectors.
    for (int i = 0; i < 6; i++) begin
      mem[8'h21] = vecs[i].ss;   mem[8'h22] = vecs[i].mm;   mem[8'h23] = vecs[i].hh;
      mem[8'h24] = vecs[i].day;  mem[8'h25] = vecs[i].mes;  mem[8'h26] = vecs[i].year;
      mem[8'h27] = vecs[i].wd;   mem[8'h41] = vecs[i].sst;  mem[8'h42] = vecs[i].mmt;
      mem[8'h43] = vecs[i].hht;
      run_frame();
      check($sformatf("vec%0d_all", i), obs[0], model());
      check($sformatf("vec%0d_ampm", i), obs[0][72], vecs[i].exp_ampm);
      check($sformatf("vec%0d_hh1", i), obs[0][23:20], vecs[i].exp_hh1);
      check($sformatf("vec%0d_dia", i), obs[0][75:73], vecs[i].exp_dia);
    end

    // Randomised register contents.
    for (int i = 0; i < 8; i++) begin
      mem[8'h21] = 8'($urandom); mem[8'h22] = 8'($urandom); mem[8'h23] = 8'($urandom);
      mem[8'h24] = 8'($urandom); mem[8'h25] = 8'($urandom); mem[8'h26] = 8'($urandom);
      mem[8'h27] = 8'($urandom); mem[8'h41] = 8'($urandom); mem[8'h42] = 8'($urandom);
      mem[8'h43] = 8'($urandom);
      run_frame();
      check($sformatf("rand%0d_all", i), obs[0], model());
    end

    check("sweeps_b_seen", sweeps[1] >= 3, 1'b1);
    check("protocol_a", viol[0], 0);
    check("protocol_b", viol[1], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rtc_register_reader.md
# rtc_register_reader

Read-side controller for the external real-time-clock chip's multiplexed address/data bus. It periodically sweeps the ten RTC time, date and timer registers and splits each BCD byte into the digit nibbles, AM/PM flag and weekday code consumed by the VGA clock screen. It sits between the RTC pin interface (tristate pad outside this block) and the screen's digit inputs. It commits a fresh, self-consistent snapshot once per refresh period.

## Interface
- PULSE_CYC, 10, low width of each wr_n/rd_n strobe in clock cycles (1..255)
- REFRESH_CYC, 10_000_000, cycles between sweep starts (≥ sweep length, 2..2^24)
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ad_in  in  8  data sampled from RTC AD bus
- ad_out  out  8  address driven onto AD bus
- ad_oe  out  1  1 = pad drives ad_out onto the bus
- cs_n, rd_n, wr_n  out  1 each  RTC chip select, read strobe, write strobe (active low)
- a_d  out  1  0 = address phase, 1 = data phase
- digit0_SS/MM/HH, digit1_SS/MM/HH  out  4 each  clock seconds/minutes/hours (digit0 = units, digit1 = tens)
- digit0_DAY/MES/YEAR, digit1_DAY/MES/YEAR  out  4 each  date
- digit0_SS_T/MM_T/HH_T, digit1_SS_T/MM_T/HH_T  out  4 each  timer
- AM_PM  out  1  1 = PM
- dia_semana  out  3  weekday code 0..6
- busy  out  1  sweep in progress
- frame_done  out  1  one-cycle pulse on snapshot commit

## Operation
- Sweep order and addresses: SS 0x21, MM 0x22, HH 0x23, DAY 0x24, MES 0x25, YEAR 0x26, weekday 0x27, SS_T 0x41, MM_T 0x42, HH_T 0x43.
- Per register, FSM states:
  - ADDR_SET (1 cycle): cs_n=0, a_d=0, ad_oe=1, ad_out=addr.
  - ADDR_WR (PULSE_CYC cycles): wr_n=0.
  - ADDR_HOLD (1 cycle): wr_n=1, still driving.
  - DATA_SET (1 cycle): ad_oe=0, a_d=1.
  - DATA_RD (PULSE_CYC cycles): rd_n=0; ad_in latched into shadow on the last cycle.
  - DATA_HOLD (1 cycle): rd_n=1, cs_n=1, a_d=0.
- After register 10: COMMIT (1 cycle) copies all shadows to outputs simultaneously, pulses frame_done, then IDLE.
- Byte decode:
  - Generic: digit0 = b[3:0], digit1 = b[7:4].
  - HH: digit1_HH = {2'b00, b[5:4]}, AM_PM = b[7]; b[6] ignored.
  - HH_T: digit1 = {2'b00, b[5:4]}.
  - Weekday: dia_semana = b[2:0]; value 7 stored as-is.
- No BCD validation; nibbles pass through unchanged.
- Outputs never change mid-sweep. The display sees only whole snapshots.
- Idle bus: cs_n=rd_n=wr_n=1, a_d=0, ad_oe=0, ad_out=0. rd_n and wr_n are never both low. ad_oe=0 whenever rd_n=0.

## Timing
- Reset asserted, at any time including mid-sweep: immediately all strobes high, ad_oe=0, a_d=0, ad_out=0; every digit, AM_PM, dia_semana = 0; busy=0, frame_done=0; FSM to IDLE; refresh counter cleared.
- First sweep starts the first clock edge after reset deasserts (busy=1 that cycle, ADDR_SET).
- Register slot = 4 + 2·PULSE_CYC cycles. Sweep = 10 slots + 1 COMMIT; default 241 cycles.
- Refresh counter free-runs modulo REFRESH_CYC from sweep start. Terminal count while IDLE starts a sweep next cycle. Terminal count while busy is dropped, not queued.
- frame_done is high in the COMMIT cycle; new outputs are visible from the following cycle. busy falls the cycle after COMMIT.

## Structure
- Shared package rtc_pkg: register address constants, FSM state enum, register-index type (0..9).
- Sub-module rtc_bus_cycle: one address-write plus data-read transaction (start/addr in, done/data out, owns strobes and PULSE_CYC counter). The top sequences indexes, holds shadows and commits.

## Test plan
- Reset then release with behavioral RTC holding HH=0x91, MM=0x45, SS=0x30 → after frame_done: AM_PM=1, digit1_HH=1, digit0_HH=1, MM=4/5, SS=3/0; first ADDR_SET at cycle 1 after release.
- PULSE_CYC=3 → each wr_n and rd_n low exactly 3 cycles; sweep length 101 cycles; address sequence 0x21..0x27, 0x41..0x43.
- Model changes SS from 0x59 to 0x00 mid-sweep (after SS slot) → outputs stay at the previous snapshot until COMMIT, then SS=5/9; next sweep shows 0/0.
- Reset asserted during DATA_RD of register 5 → same cycle rd_n=1, cs_n=1, all outputs 0; restart at cycle 1 after release.
- REFRESH_CYC=150, PULSE_CYC=10 (sweep 241) → terminal counts during busy are ignored; no back-to-back overlap; bus-contention checker (ad_oe=1 while rd_n=0) never fires.
- Weekday byte 0xFE, YEAR 0x9A → dia_semana=6, digit1_YEAR=9, digit0_YEAR=0xA passed unchanged.
